// File: rtl/reg_file_2w2r.sv
// Two-write / two-read MIPS register file with an optional hardwired zero entry,
// same-cycle write-to-read forwarding and a post-reset sequencer that zeroes every entry.
module reg_file_2w2r #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] RsAddr,
  input  logic [ADDR_W-1:0] RtAddr,
  output logic [DATA_W-1:0] RsData,
  output logic [DATA_W-1:0] RtData,
  input  logic              RegWrA,
  input  logic [ADDR_W-1:0] WrAddrA,
  input  logic [DATA_W-1:0] DataInA,
  input  logic              RegWrB,
  input  logic [ADDR_W-1:0] WrAddrB,
  input  logic [DATA_W-1:0] DataInB,
  output logic              Busy
);

  localparam int NREGS = 1 << ADDR_W;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   regs_q [NREGS];

  logic                clr_en_s;
  logic                wr_a_en_s;
  logic                wr_b_en_s;
  logic [ADDR_W-1:0]   rd_addr_s [2];
  logic [DATA_W-1:0]   rd_data_s [2];

  // State, clear pointer and Busy flag; Reset restarts the clear sequence from entry 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_CLEAR;
      ptr_q   <= {ADDR_W{1'b0}};
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: walk the pointer through every entry, then drop into RUN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      S_CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1'b1);
        if (ptr_q == {ADDR_W{1'b1}}) begin
          state_d = S_RUN;
          busy_d  = 1'b0;
        end else begin
          state_d = S_CLEAR;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_CLEAR;
        ptr_d   = {ADDR_W{1'b0}};
        busy_d  = 1'b1;
      end
    endcase
  end

  // Write strobes: clearing owns the array in CLEAR; in RUN port B beats port A on an address clash.
  always_comb begin
    clr_en_s  = 1'b0;
    wr_a_en_s = 1'b0;
    wr_b_en_s = 1'b0;
    if (Reset) begin
      clr_en_s = 1'b0;
    end else if (state_q == S_CLEAR) begin
      clr_en_s = 1'b1;
    end else begin
      wr_b_en_s = RegWrB && !((ZERO_REG != 0) && (WrAddrB == {ADDR_W{1'b0}}));
      wr_a_en_s = RegWrA && !((ZERO_REG != 0) && (WrAddrA == {ADDR_W{1'b0}}))
                         && !(RegWrB && (WrAddrA == WrAddrB));
    end
  end

  // Storage array; no reset of its own since the clear sequencer zeroes it.
  always_ff @(posedge Clk) begin
    if (clr_en_s) begin
      regs_q[ptr_q] <= {DATA_W{1'b0}};
    end else begin
      if (wr_a_en_s) begin
        regs_q[WrAddrA] <= DataInA;
      end
      if (wr_b_en_s) begin
        regs_q[WrAddrB] <= DataInB;
      end
    end
  end

  assign rd_addr_s[0] = RsAddr;
  assign rd_addr_s[1] = RtAddr;

  // Read mux per port: busy blanking, zero entry, B-forward, A-forward, then stored value.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_s[p] = {DATA_W{1'b0}};
      if (busy_q) begin
        rd_data_s[p] = {DATA_W{1'b0}};
      end else if ((ZERO_REG != 0) && (rd_addr_s[p] == {ADDR_W{1'b0}})) begin
        rd_data_s[p] = {DATA_W{1'b0}};
      end else if ((BYPASS != 0) && RegWrB && (WrAddrB == rd_addr_s[p])) begin
        rd_data_s[p] = DataInB;
      end else if ((BYPASS != 0) && RegWrA && (WrAddrA == rd_addr_s[p])) begin
        rd_data_s[p] = DataInA;
      end else begin
        rd_data_s[p] = regs_q[rd_addr_s[p]];
      end
    end
  end

  assign RsData = rd_data_s[0];
  assign RtData = rd_data_s[1];
  assign Busy   = busy_q;

endmodule

// File: tb/tb_reg_file_2w2r.sv
// Scoreboarded bench for reg_file_2w2r: a default instance and a small 16-bit/8-entry
// instance without bypass or zero register, both checked against an array-based model.
module tb_reg_file_2w2r;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        rst  [2];
  logic [4:0]  rs_a [2];
  logic [4:0]  rt_a [2];
  logic        wea  [2];
  logic [4:0]  wa_a [2];
  logic [31:0] da   [2];
  logic        web  [2];
  logic [4:0]  wb_a [2];
  logic [31:0] db   [2];

  logic [31:0] rsd0, rtd0;
  logic [15:0] rsd1, rtd1;
  logic        busy0, busy1;

  reg_file_2w2r u_dut0 (
    .Clk(Clk), .Reset(rst[0]), .RsAddr(rs_a[0]), .RtAddr(rt_a[0]),
    .RsData(rsd0), .RtData(rtd0),
    .RegWrA(wea[0]), .WrAddrA(wa_a[0]), .DataInA(da[0]),
    .RegWrB(web[0]), .WrAddrB(wb_a[0]), .DataInB(db[0]),
    .Busy(busy0)
  );

  reg_file_2w2r #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .Clk(Clk), .Reset(rst[1]), .RsAddr(rs_a[1][2:0]), .RtAddr(rt_a[1][2:0]),
    .RsData(rsd1), .RtData(rtd1),
    .RegWrA(wea[1]), .WrAddrA(wa_a[1][2:0]), .DataInA(da[1][15:0]),
    .RegWrB(web[1]), .WrAddrB(wb_a[1][2:0]), .DataInB(db[1][15:0]),
    .Busy(busy1)
  );

  typedef struct {
    int          id;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: per-instance contents, remaining clear cycles and configuration.
  logic [31:0] mem     [2][32];
  int          remain  [2];
  bit          known   [2] = '{1'b0, 1'b0};
  int          nregs   [2] = '{32, 8};
  bit          zr      [2] = '{1'b1, 1'b0};
  bit          byp     [2] = '{1'b1, 1'b0};
  logic [31:0] dmask   [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};
  logic [4:0]  amask   [2] = '{5'd31, 5'd7};

  function automatic logic [31:0] model_read(int id, logic [4:0] a);
    if (remain[id] > 0) return 32'h0;
    if (zr[id] && a == 5'd0) return 32'h0;
    if (byp[id] && web[id] && wb_a[id] == a) return db[id];
    if (byp[id] && wea[id] && wa_a[id] == a) return da[id];
    return mem[id][a];
  endfunction

  task automatic drive(int id, logic r, logic [4:0] rs, logic [4:0] rt,
                       logic we_a, logic [4:0] a_a, logic [31:0] d_a,
                       logic we_b, logic [4:0] a_b, logic [31:0] d_b);
    rst[id]  = r;
    rs_a[id] = rs & amask[id];
    rt_a[id] = rt & amask[id];
    wea[id]  = we_a;
    wa_a[id] = a_a & amask[id];
    da[id]   = d_a & dmask[id];
    web[id]  = we_b;
    wb_a[id] = a_b & amask[id];
    db[id]   = d_b & dmask[id];
  endtask

  task automatic idle(int id, logic [4:0] rs, logic [4:0] rt);
    drive(id, 1'b0, rs, rt, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // One clock: queue expectations for the held inputs, then advance the model at the edge.
  task automatic step(string tag);
    exp_t e;
    for (int id = 0; id < 2; id++) begin
      if (known[id]) begin
        e.id   = id;
        e.rs   = model_read(id, rs_a[id]);
        e.rt   = model_read(id, rt_a[id]);
        e.busy = (remain[id] > 0);
        e.tag  = tag;
        sb_q.push_back(e);
      end
    end
    @(posedge Clk);
    for (int id = 0; id < 2; id++) begin
      if (rst[id]) begin
        known[id]  = 1'b1;
        remain[id] = nregs[id];
        for (int k = 0; k < 32; k++) mem[id][k] = 32'h0;
      end else if (known[id]) begin
        if (remain[id] > 0) begin
          remain[id] = remain[id] - 1;
        end else begin
          if (wea[id] && !(zr[id] && wa_a[id] == 5'd0)) mem[id][wa_a[id]] = da[id];
          if (web[id] && !(zr[id] && wb_a[id] == 5'd0)) mem[id][wb_a[id]] = db[id];
        end
      end
    end
    #1;
  endtask

  // Monitor: the read ports and Busy are valid mid-cycle; compare on the falling edge.
  always @(negedge Clk) begin
    exp_t        e;
    logic [31:0] ars, art;
    logic        abusy;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.id == 0) begin
        ars = rsd0; art = rtd0; abusy = busy0;
      end else begin
        ars = {16'h0, rsd1}; art = {16'h0, rtd1}; abusy = busy1;
      end
      checks++;
      if (ars !== e.rs || art !== e.rt || abusy !== e.busy) begin
        failures++;
        $display("FAIL %s dut%0d rs=%h exp=%h rt=%h exp=%h busy=%b exp=%b",
                 e.tag, e.id, ars, e.rs, art, e.rt, abusy, e.busy);
      end
    end
  end

  initial begin
    for (int id = 0; id < 2; id++) begin
      idle(id, 5'd0, 5'd0);
      rst[id] = 1'b1;
    end
    repeat (3) step("reset");
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int i = 0; i < 32; i++) begin
      idle(0, 5'(i), 5'(31 - i));
      idle(1, 5'(i), 5'(7 - (i % 8)));
      step("clear");
    end
    for (int i = 0; i < 32; i++) begin
      idle(0, 5'(i), 5'(31 - i));
      idle(1, 5'(i), 5'(i));
      step("zero_sweep");
    end

    // Single write with bypass, then stored readback.
    drive(0, 1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'h0);
    step("bypass_a");
    idle(0, 5'd5, 5'd6);
    step("stored_a");

    // Colliding writes: B wins both forward and storage.
    drive(0, 1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 32'hAAAA_AAAA, 1'b1, 5'd7, 32'hBBBB_BBBB);
    step("collide_bypass");
    idle(0, 5'd7, 5'd5);
    step("collide_stored");

    // Address 0: hardwired on dut0, ordinary on dut1.
    drive(0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
    drive(1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
    step("zero_write");
    idle(0, 5'd0, 5'd0);
    idle(1, 5'd0, 5'd0);
    step("zero_read");

    // No bypass on dut1: write invisible this cycle, visible next.
    drive(1, 1'b0, 5'd2, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h0000_BEEF);
    step("nobyp_write");
    idle(1, 5'd2, 5'd0);
    step("nobyp_read");

    // Reset mid-clear restarts the full sequence; writes during Busy are dropped.
    drive(0, 1'b0, 5'd3, 5'd3, 1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 32'h0);
    step("pre_reset_write");
    idle(0, 5'd3, 5'd3);
    rst[0] = 1'b1;
    step("reset_pulse");
    rst[0] = 1'b0;
    repeat (10) step("partial_clear");
    rst[0] = 1'b1;
    step("reset_again");
    for (int i = 0; i < 32; i++) begin
      drive(0, 1'b0, 5'd3, 5'(i), 1'b1, 5'd3, 32'h5, 1'b0, 5'd0, 32'h0);
      step("busy_write");
    end
    idle(0, 5'd3, 5'd3);
    step("post_clear_read");

    // Random traffic on both instances, addresses biased to collide, occasional reset.
    for (int n = 0; n < 800; n++) begin
      for (int id = 0; id < 2; id++) begin
        logic [4:0] ra, rb, a1, a2;
        ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        rb = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        a2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        drive(id, ($urandom_range(0, 99) == 0), ra, rb,
              1'($urandom), a1, $urandom, 1'($urandom), a2, $urandom);
      end
      step("random");
    end

    idle(0, 5'd0, 5'd0);
    idle(1, 5'd0, 5'd0);
    step("drain");
    @(negedge Clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
